tart_vis_prefetch: RTL and testbench

Bus-domain readout engine that sits directly downstream of the TART correlator. On each bank-swap pulse from the correlator it sweeps every visibility word of every correlator block with sequential Wishbone-like reads. It queues the words in a small FIFO and presents them as a valid/ready stream with frame markers to the host-interface (SPI) stage.

---
 rtl/tart_vis_prefetch.sv | 181 ++++++++++++++++++
 tb/tb_tart_vis_prefetch.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tart_vis_prefetch.sv
// tart_vis_prefetch: after each correlator bank swap, reads every visibility word of every
// correlator block over a Wishbone-like bus (one read outstanding at a time). The words pass
// through a small first-word-fall-through FIFO and leave as a valid/ready stream with
// first/last frame markers.
module tart_vis_prefetch #(
  parameter int unsigned BLOCK   = 24,
  parameter int unsigned ABITS   = 14,
  parameter int unsigned NUNITS  = 6,
  parameter int unsigned WORDS   = 24,
  parameter int unsigned FBITS   = 2,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned DELAY   = 3
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             enable,
  input  logic             switch_i,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic             bst_o,
  output logic [ABITS-1:0] adr_o,
  input  logic             ack_i,
  input  logic             err_i,
  input  logic [BLOCK-1:0] dat_i,
  output logic [BLOCK-1:0] vis_dat_o,
  output logic             vis_vld_o,
  input  logic             vis_rdy_i,
  output logic             vis_first_o,
  output logic             vis_last_o,
  output logic             busy_o,
  output logic             overrun_o,
  output logic             fault_o,
  input  logic             clr_i,
  output logic [7:0]       frames_o
);

  localparam int unsigned Depth   = 1 << FBITS;
  localparam int unsigned TmoBits = $clog2(TIMEOUT + 1);
  localparam int unsigned EntryW  = BLOCK + 2;
  localparam logic [2:0]  LastUnit = 3'(NUNITS - 1);
  localparam logic [6:0]  LastWord = 7'(WORDS - 1);

  // Out-of-range parameters leave this block elaborated; it carries no logic.
  if (NUNITS < 1 || NUNITS > 6 || WORDS < 1 || WORDS > 128 || ABITS <= 10 ||
      DELAY > 1000) begin : g_param_range
  end

  typedef enum logic [1:0] {StIdle, StReq, StNext} state_e;

  state_e             r_state;
  logic [2:0]         r_unit;
  logic [6:0]         r_word;
  logic [TmoBits-1:0] r_tmo;

  logic [EntryW-1:0]  r_mem [Depth];
  logic [FBITS-1:0]   r_wptr, r_rptr;
  logic [FBITS:0]     r_cnt;

  logic               w_push, w_pop, w_abort, w_final, w_first, w_room, w_tmo_hit;
  logic [EntryW-1:0]  w_head;

  // err_i takes priority over a simultaneous ack_i; an ack on the last allowed cycle still counts
  assign w_tmo_hit = (r_tmo == TmoBits'(TIMEOUT - 1));
  assign w_abort   = (r_state == StReq) && (err_i || (!ack_i && w_tmo_hit));
  assign w_push    = (r_state == StReq) && ack_i && !err_i;
  assign w_final   = (r_unit == LastUnit) && (r_word == LastWord);
  assign w_first   = (r_unit == 3'd0) && (r_word == 7'd0);
  // Count MSB set means the FIFO holds all Depth entries
  assign w_room    = !r_cnt[FBITS];

  assign we_o   = 1'b0;
  assign busy_o = (r_state != StIdle);

  // Sweep sequencer: address generation, strobe/timeout handling and frame counting
  always_ff @(posedge clk_i) begin
    if (rst) begin
      r_state  <= StIdle;
      r_unit   <= '0;
      r_word   <= '0;
      r_tmo    <= '0;
      cyc_o    <= 1'b0;
      stb_o    <= 1'b0;
      bst_o    <= 1'b0;
      adr_o    <= '0;
      frames_o <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (switch_i && enable) begin
            r_state <= StReq;
            r_unit  <= '0;
            r_word  <= '0;
            r_tmo   <= '0;
            cyc_o   <= 1'b1;
            stb_o   <= 1'b1;
            adr_o   <= '0;
            bst_o   <= (LastWord != 7'd0);
          end
        end
        StReq: begin
          if (w_abort) begin
            r_state <= StIdle;
            cyc_o   <= 1'b0;
            stb_o   <= 1'b0;
            bst_o   <= 1'b0;
            adr_o   <= '0;
          end else if (w_push) begin
            stb_o <= 1'b0;
            bst_o <= 1'b0;
            if (w_final) begin
              r_state  <= StIdle;
              cyc_o    <= 1'b0;
              adr_o    <= '0;
              frames_o <= frames_o + 8'd1;
            end else begin
              r_state <= StNext;
              if (r_word == LastWord) begin
                r_word <= '0;
                r_unit <= r_unit + 3'd1;
              end else begin
                r_word <= r_word + 7'd1;
              end
            end
          end else begin
            r_tmo <= r_tmo + TmoBits'(1);
          end
        end
        StNext: begin
          // Wait for a free FIFO slot so the single outstanding read can always be accepted
          if (w_room) begin
            r_state <= StReq;
            r_tmo   <= '0;
            stb_o   <= 1'b1;
            adr_o   <= {{(ABITS - 10){1'b0}}, r_unit, r_word};
            bst_o   <= (r_word != LastWord);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Sticky status flags; a setting event beats a simultaneous clear
  always_ff @(posedge clk_i) begin
    if (rst) begin
      overrun_o <= 1'b0;
      fault_o   <= 1'b0;
    end else begin
      if (switch_i && busy_o) overrun_o <= 1'b1;
      else if (clr_i)         overrun_o <= 1'b0;
      if (w_abort)            fault_o   <= 1'b1;
      else if (clr_i)         fault_o   <= 1'b0;
    end
  end

  // First-word-fall-through FIFO holding {data, first, last}
  always_ff @(posedge clk_i) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= {dat_i, w_first, w_final};
        r_wptr        <= r_wptr + FBITS'(1);
      end
      if (w_pop) r_rptr <= r_rptr + FBITS'(1);
      r_cnt <= r_cnt + {{FBITS{1'b0}}, w_push} - {{FBITS{1'b0}}, w_pop};
    end
  end

  assign w_head      = r_mem[r_rptr];
  assign vis_vld_o   = (r_cnt != '0);
  assign w_pop       = vis_vld_o && vis_rdy_i;
  // Stream outputs read as zero while empty so stale storage never shows
  assign vis_dat_o   = vis_vld_o ? w_head[EntryW-1:2] : '0;
  assign vis_first_o = vis_vld_o && w_head[1];
  assign vis_last_o  = vis_vld_o && w_head[0];

endmodule

// File: tb/tb_tart_vis_prefetch.sv
// Bench for tart_vis_prefetch: directed sweeps plus randomized traffic, checked each cycle
// against a transaction-level model (expected address index, output queue, sticky flags).
`timescale 1ns/1ps
module tb_tart_vis_prefetch;
  localparam int BLOCK = 24, ABITS = 14, NUNITS = 6, WORDS = 24, FBITS = 2, TIMEOUT = 15;
  localparam int NW = NUNITS * WORDS;

  logic clk = 1'b0;
  logic rst = 1'b1, enable = 1'b0, switch_i = 1'b0, ack_i = 1'b0, err_i = 1'b0;
  logic vis_rdy_i = 1'b0, clr_i = 1'b0;
  logic [BLOCK-1:0] dat_i = '0;
  logic cyc_o, stb_o, we_o, bst_o, vis_vld_o, vis_first_o, vis_last_o, busy_o;
  logic overrun_o, fault_o;
  logic [ABITS-1:0] adr_o;
  logic [BLOCK-1:0] vis_dat_o;
  logic [7:0] frames_o;

  always #5 clk = ~clk;

  tart_vis_prefetch #(
    .BLOCK(BLOCK), .ABITS(ABITS), .NUNITS(NUNITS), .WORDS(WORDS), .FBITS(FBITS),
    .TIMEOUT(TIMEOUT), .DELAY(3)
  ) dut (
    .clk_i(clk), .rst(rst), .enable(enable), .switch_i(switch_i), .cyc_o(cyc_o),
    .stb_o(stb_o), .we_o(we_o), .bst_o(bst_o), .adr_o(adr_o), .ack_i(ack_i), .err_i(err_i),
    .dat_i(dat_i), .vis_dat_o(vis_dat_o), .vis_vld_o(vis_vld_o), .vis_rdy_i(vis_rdy_i),
    .vis_first_o(vis_first_o), .vis_last_o(vis_last_o), .busy_o(busy_o),
    .overrun_o(overrun_o), .fault_o(fault_o), .clr_i(clr_i), .frames_o(frames_o)
  );

  typedef struct packed {
    logic [BLOCK-1:0] dat;
    logic             first;
    logic             last;
  } item_t;

  // Model state
  item_t    q[$];
  bit       m_busy, m_stb, m_ovr, m_fault;
  int       m_k, m_tmo;
  bit [7:0] m_frames;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;

  // Stimulus controls
  bit drv_sw, drv_clr, drv_en, drv_rst, drv_rdy;
  int p_rdy_mode = 0, p_rdy_limit = 0, p_wmin = 0, p_err_adr = -1;
  int p_sw1 = -1, p_sw2 = -1, p_rst_k = -1;
  bit p_noack, p_rand_wait, p_rand_err, p_dat_adr;
  int s_cnt = 0, s_target = 0;

  // Observed deliveries
  int n_pop, n_first, n_last, n_order_err, n_stb, n_bst_low, rst_qsize, nb;
  logic [BLOCK-1:0] last_dat, first_dat;

  function automatic int exp_adr(input int k);
    return ((k / WORDS) << 7) | (k % WORDS);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp,
               $time);
    end
  endtask

  task automatic clear_obs();
    n_pop = 0; n_first = 0; n_last = 0; n_order_err = 0; n_stb = 0; n_bst_low = 0;
  endtask

  task automatic compare();
    chk("busy", busy_o, m_busy);
    chk("cyc", cyc_o, m_busy);
    chk("stb", stb_o, m_stb);
    chk("we", we_o, 0);
    if (m_stb) begin
      chk("adr", adr_o, exp_adr(m_k));
      chk("bst", bst_o, (m_k % WORDS) != WORDS - 1);
    end else if (!m_busy) begin
      chk("adr_idle", adr_o, 0);
      chk("bst_idle", bst_o, 0);
    end
    chk("vld", vis_vld_o, q.size() != 0);
    if (q.size() != 0) begin
      chk("vdat", vis_dat_o, q[0].dat);
      chk("vfirst", vis_first_o, q[0].first);
      chk("vlast", vis_last_o, q[0].last);
    end
    chk("overrun", overrun_o, m_ovr);
    chk("fault", fault_o, m_fault);
    chk("frames", frames_o, m_frames);
  endtask

  // Advances the model across one clock edge given the inputs applied for this cycle
  task automatic model_step(input bit a, input bit e, input bit sw, input bit rs, input bit rdy);
    bit   room, abort;
    item_t it;
    if (rs) begin
      q.delete();
      m_busy = 0; m_stb = 0; m_ovr = 0; m_fault = 0; m_k = 0; m_tmo = 0; m_frames = 0;
      return;
    end
    room  = (q.size() <= (1 << FBITS) - 1);
    abort = 0;
    if (q.size() != 0 && rdy) void'(q.pop_front());
    if (sw && m_busy) m_ovr = 1;
    else if (drv_clr) m_ovr = 0;
    if (!m_busy) begin
      if (sw && drv_en) begin
        m_busy = 1; m_stb = 1; m_k = 0; m_tmo = 0;
      end
    end else if (m_stb) begin
      if (e || (!a && m_tmo == TIMEOUT - 1)) begin
        m_busy = 0; m_stb = 0; abort = 1;
      end else if (a) begin
        it.dat = dat_i; it.first = (m_k == 0); it.last = (m_k == NW - 1);
        q.push_back(it);
        m_stb = 0;
        if (m_k == NW - 1) begin
          m_busy = 0; m_frames = m_frames + 8'd1;
        end else begin
          m_k++;
        end
      end else begin
        m_tmo++;
      end
    end else if (room) begin
      m_stb = 1; m_tmo = 0;
    end
    if (abort) m_fault = 1;
    else if (drv_clr) m_fault = 0;
  endtask

  task automatic cycle();
    bit a, e, sw, rs, rdy;
    @(negedge clk);
    if (chk_en) compare();
    if (stb_o) n_stb++;
    if (stb_o && !bst_o) n_bst_low++;
    a = 0; e = 0; rs = drv_rst;
    if (stb_o) begin
      if (s_cnt == 0) begin
        if (p_rand_wait)
          s_target = ($urandom_range(49, 0) == 0) ? $urandom_range(16, 3) : $urandom_range(2, 0);
        else
          s_target = p_wmin;
      end
      if (p_err_adr >= 0 && int'(adr_o) == p_err_adr) e = 1;
      else if (!p_noack && s_cnt >= s_target) begin
        a = 1;
        if (p_rand_err && $urandom_range(999, 0) == 0) e = 1;
      end else if (p_rand_err && $urandom_range(1999, 0) == 0) e = 1;
      if (p_rst_k >= 0 && m_k == p_rst_k) begin
        rs = 1; a = 0; e = 0; rst_qsize = q.size(); p_rst_k = -1;
      end
      s_cnt++;
    end else begin
      s_cnt = 0;
    end
    sw = drv_sw || (a && !e && (m_k + 1 == p_sw1 || m_k + 1 == p_sw2));
    if (p_rdy_mode == 0)      rdy = drv_rdy;
    else if (p_rdy_mode == 1) rdy = ($urandom_range(3, 0) != 0);
    else                      rdy = (n_pop < p_rdy_limit);
    ack_i = a; err_i = e; switch_i = sw; rst = rs; clr_i = drv_clr; enable = drv_en;
    vis_rdy_i = rdy;
    dat_i = p_dat_adr ? BLOCK'(adr_o) : BLOCK'($urandom);
    if (!rs && vis_vld_o && rdy) begin
      if (p_dat_adr && vis_dat_o != BLOCK'(exp_adr(n_pop))) n_order_err++;
      if (vis_first_o) begin n_first++; first_dat = vis_dat_o; end
      if (vis_last_o) n_last++;
      last_dat = vis_dat_o;
      n_pop++;
    end
    model_step(a, e, sw, rs, rdy);
  endtask

  task automatic start_sweep();
    drv_sw = 1; cycle(); drv_sw = 0;
  endtask

  task automatic wait_idle(input int limit, output int busy_n);
    bit done;
    done = 0; busy_n = 0;
    for (int i = 0; i < limit && !done; i++) begin
      cycle();
      if (busy_o) busy_n++;
      else done = 1;
    end
    n_chk++;
    if (!done) begin
      n_fail++;
      $display("FAIL wait_idle: busy_o still 1 after %0d cycles, expected 0", limit);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    drv_en = 1; drv_rdy = 1;
    // Reset
    drv_rst = 1; cycle(); chk_en = 1; cycle(); cycle(); drv_rst = 0; cycle();
    chk("rst_busy", busy_o, 0); chk("rst_stb", stb_o, 0); chk("rst_adr", adr_o, 0);
    chk("rst_vld", vis_vld_o, 0); chk("rst_frames", frames_o, 0);
    chk("rst_flags", {overrun_o, fault_o}, 0);

    // A: full sweep, zero-wait acks, data = address
    p_dat_adr = 1; p_wmin = 0; clear_obs();
    start_sweep();
    wait_idle(2000, nb);
    repeat (6) cycle();
    chk("A_busy_cycles", nb, 287); chk("A_words", n_pop, 144); chk("A_order", n_order_err, 0);
    chk("A_first_cnt", n_first, 1); chk("A_first_dat", first_dat, 0);
    chk("A_last_cnt", n_last, 1); chk("A_last_dat", last_dat, 'h297);
    chk("A_frames", frames_o, 1); chk("A_strobes", n_stb, 144); chk("A_bst_low", n_bst_low, 6);

    // B: stream stall mid-sweep
    clear_obs();
    start_sweep();
    repeat (40) cycle();
    drv_rdy = 0;
    repeat (10) cycle();
    n_stb = 0;
    repeat (30) cycle();
    chk("B_stall_stb", n_stb, 0); chk("B_model_depth", q.size(), 4);
    chk("B_vld", vis_vld_o, 1); chk("B_busy", busy_o, 1);
    drv_rdy = 1;
    wait_idle(2000, nb);
    repeat (6) cycle();
    chk("B_words", n_pop, 144); chk("B_order", n_order_err, 0); chk("B_last", n_last, 1);
    chk("B_frames", frames_o, 2);

    // C: swap at the 50th ack and at the final ack
    clear_obs(); p_wmin = 1; p_sw1 = 50; p_sw2 = 144;
    start_sweep();
    wait_idle(3000, nb);
    repeat (6) cycle();
    p_sw1 = -1; p_sw2 = -1;
    chk("C_overrun", overrun_o, 1); chk("C_words", n_pop, 144); chk("C_order", n_order_err, 0);
    chk("C_idle", busy_o, 0); chk("C_frames", frames_o, 3);
    drv_clr = 1; cycle(); drv_clr = 0; cycle();
    chk("C_clr", overrun_o, 0);

    // D: bus error on unit 2 word 5, then a clean sweep
    clear_obs(); p_wmin = 0; p_err_adr = 'h105;
    start_sweep();
    wait_idle(2000, nb);
    repeat (6) cycle();
    p_err_adr = -1;
    chk("D_fault", fault_o, 1); chk("D_words", n_pop, 53); chk("D_no_last", n_last, 0);
    chk("D_order", n_order_err, 0); chk("D_frames", frames_o, 3);
    clear_obs();
    start_sweep();
    cycle();
    chk("D_restart_adr", adr_o, 0); chk("D_restart_stb", stb_o, 1); chk("D_restart_cyc", cyc_o, 1);
    wait_idle(2000, nb);
    repeat (6) cycle();
    chk("D2_words", n_pop, 144); chk("D2_order", n_order_err, 0); chk("D2_frames", frames_o, 4);

    // E: slave never responds
    drv_clr = 1; cycle(); drv_clr = 0; cycle();
    chk("E_fault_clr", fault_o, 0);
    clear_obs(); p_noack = 1;
    start_sweep();
    n_stb = 0;
    repeat (60) cycle();
    p_noack = 0;
    chk("E_stb_cycles", n_stb, 15); chk("E_fault", fault_o, 1); chk("E_busy", busy_o, 0);
    chk("E_no_push", n_pop, 0); chk("E_vld", vis_vld_o, 0);

    // F: reset during the 10th read with 3 words queued
    clear_obs(); p_rdy_mode = 2; p_rdy_limit = 6; p_rst_k = 9;
    start_sweep();
    for (int i = 0; i < 300 && p_rst_k >= 0; i++) cycle();
    chk("F_rst_reached", p_rst_k, -1);
    p_rst_k = -1;
    cycle();
    p_rdy_mode = 0;
    chk("F_queued", rst_qsize, 3); chk("F_popped", n_pop, 6);
    chk("F_busy", busy_o, 0); chk("F_cyc", cyc_o, 0); chk("F_stb", stb_o, 0);
    chk("F_adr", adr_o, 0); chk("F_vld", vis_vld_o, 0); chk("F_dat", vis_dat_o, 0);
    chk("F_frames", frames_o, 0); chk("F_flags", {overrun_o, fault_o}, 0);

    // G: randomized traffic
    p_rand_wait = 1; p_rand_err = 1; p_dat_adr = 0; p_rdy_mode = 1;
    for (int i = 0; i < 8000; i++) begin
      drv_sw  = ($urandom_range(149, 0) == 0);
      drv_en  = ($urandom_range(7, 0) != 0);
      drv_clr = ($urandom_range(399, 0) == 0);
      drv_rst = ($urandom_range(2999, 0) == 0);
      cycle();
    end
    drv_sw = 0; drv_clr = 0; drv_rst = 0; drv_en = 1;
    repeat (20) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
